button_debounce_multi: RTL and testbench
========================================

Name: button_debounce_multi

Overview:
- Parametrised N-channel push-button conditioner: synchroniser, tick-sampled shift-register debounce with hysteresis, and one-cycle press/release pulses per channel.
- Adds long-press detection and optional auto-repeat while held.
- Sits between board button pins and the stopwatch/sensor control FSMs.
- One shared tick divider serves all channels; everything runs in the single clk domain, with no derived clocks.

Parameters:
- N_BTN, 4: number of independent button channels.
- CLK_DIV, 100: clk cycles per sample tick (>=2).
- DEPTH, 8: samples that must agree before the level changes (>=2).
- LONG_TICKS, 1000: ticks of continuous debounced-high before o_long fires (>=1).
- REPEAT_EN, 1: 1 enables o_repeat; 0 ties o_repeat to 0.
- REPEAT_TICKS, 200: ticks between o_repeat pulses after o_long (>=1).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- i_btn  input  N_BTN  raw asynchronous button inputs, bit k = channel k.
- o_level  output  N_BTN  debounced level.
- o_press  output  N_BTN  one-clk pulse on debounced 0->1.
- o_release  output  N_BTN  one-clk pulse on debounced 1->0.
- o_long  output  N_BTN  one-clk pulse when the hold reaches LONG_TICKS.
- o_repeat  output  N_BTN  one-clk pulse every REPEAT_TICKS ticks after o_long while still held.

Behaviour:
- Reset (async, active-high): divider, synchronisers, shift registers, level, prev-level, hold and repeat counters all go to 0. All outputs are 0 while rst is high and in the first cycle after release.
- Tick: counter counts 0..CLK_DIV-1 and wraps. tick=1 for exactly one clk when counter==CLK_DIV-1. It is shared by all channels.
- Sync (per channel): 2-FF synchroniser i_btn -> s1 -> s2, clocked every clk.
- Shift: on a clk edge with tick=1, sh <= {s2, sh[DEPTH-1:1]}. Otherwise sh holds.
- Level register, updated every clk:
  - sh all ones -> level <= 1.
  - sh all zeros -> level <= 0.
  - otherwise hold. This is the hysteresis: a short glitch neither asserts nor drops the level.
- o_level = level.
- Edge pulses: prev <= level every clk.
  - o_press = level & ~prev.
  - o_release = ~level & prev.
  - Each is exactly 1 clk wide, coincident with the first cycle of the new level.
- Press latency from the first clk edge that samples i_btn high (stable): between 4+(DEPTH-1)*CLK_DIV and 3+DEPTH*CLK_DIV edges, depending on divider phase. Release latency is symmetric.
- Hold counter (width $clog2(LONG_TICKS+1)):
  - Cleared whenever level==0.
  - While level==1, increments on each tick; saturates at LONG_TICKS.
  - o_long pulses 1 clk on the edge where it transitions LONG_TICKS-1 -> LONG_TICKS.
- Repeat counter (0..REPEAT_TICKS-1):
  - Cleared while the hold counter is below LONG_TICKS or level==0.
  - Once saturated, increments each tick. On reaching REPEAT_TICKS-1 it wraps to 0 and pulses o_repeat for 1 clk (only if REPEAT_EN==1).
  - Result: o_repeat pulses are exactly REPEAT_TICKS*CLK_DIV clks apart; the first comes REPEAT_TICKS*CLK_DIV clks after o_long.
- Release at any point clears both counters. No o_long or o_repeat fires after o_release. A re-press restarts the full long-press timing.
- Channels are fully independent. Pulses on several channels in the same cycle are legal. o_press and o_release never both assert on one channel.
- Reset mid-hold: all outputs drop immediately. No o_release is generated. If the button is still held after reset, a fresh o_press follows after the full press latency.

Test Plan:
(All scenarios use N_BTN=2, CLK_DIV=4, DEPTH=4, LONG_TICKS=8, REPEAT_TICKS=3, REPEAT_EN=1.)
- Clean press: i_btn[0] 0->1 and held. o_press[0] is a single 1-clk pulse between edge 16 and edge 19 after the input rises; o_level[0]=1 from then; channel 1 stays all-zero.
- Bounce: i_btn[0] toggles every 3 clks for 40 clks, then stays 1. Exactly one o_press[0] and zero o_release[0] over the run.
- Glitch immunity: with o_level[0]=1, drive i_btn[0] low for 4 clks, then high. o_level[0] stays 1; no o_release[0] or o_press[0].
- Long/repeat: hold i_btn[1] for 120 clks.
  - o_long[1] fires 29..32 clks after o_press[1].
  - o_repeat[1] pulses at +12, +24, +36... clks after o_long[1].
  - On release: one o_release[1], then no further o_repeat.
- Simultaneous: both inputs rise on the same edge. o_press[1:0]=2'b11 in the same cycle, and later o_long[1:0]=2'b11 in the same cycle.
- Reset mid-hold: assert rst for 3 clks while o_level[0]=1 and the input is held.
  - All outputs are 0 during reset; no o_release.
  - A new o_press[0] appears 16..19 clks after the first post-reset edge.

Source files
------------

// File: rtl/button_debounce_multi.sv
// N-channel push-button conditioner: 2-FF synchroniser, tick-sampled debounce
// with hysteresis, press/release pulses, long-press and auto-repeat pulses.
module button_debounce_multi #(
  parameter int N_BTN        = 4,
  parameter int CLK_DIV      = 100,
  parameter int DEPTH        = 8,
  parameter int LONG_TICKS   = 1000,
  parameter int REPEAT_EN    = 1,
  parameter int REPEAT_TICKS = 200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] i_btn,
  output logic [N_BTN-1:0] o_level,
  output logic [N_BTN-1:0] o_press,
  output logic [N_BTN-1:0] o_release,
  output logic [N_BTN-1:0] o_long,
  output logic [N_BTN-1:0] o_repeat
);

  localparam int DW = $clog2(CLK_DIV);
  localparam int HW = $clog2(LONG_TICKS + 1);
  localparam int RW = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_TICKS);
  localparam logic [HW-1:0] HOLD_PRE = HW'(LONG_TICKS - 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_TICKS - 1);
  localparam bit            REP_ON   = (REPEAT_EN != 0);

  // Shared sample-tick divider
  logic [DW-1:0] r_div;
  logic          w_tick;

  assign w_tick = (r_div == DIV_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div <= '0;
    end else if (w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DW'(1);
    end
  end

  logic [N_BTN-1:0] r_s1;
  logic [N_BTN-1:0] r_s2;

  // NOTE: non-blocking assignments make r_s2 take the old r_s1, giving a true two-stage synchroniser.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= i_btn;
      r_s2 <= r_s1;
    end
  end

  for (genvar k = 0; k < N_BTN; k++) begin : g_ch
    logic [DEPTH-1:0] r_sh;
    logic             r_level;
    logic             r_prev;
    logic [HW-1:0]    r_hold;
    logic [RW-1:0]    r_rep;
    logic             r_long;
    logic             r_rep_pulse;
    logic             w_hold_full;

    assign w_hold_full = (r_hold == HOLD_MAX);

    // NOTE: the sample history is reset as well, so stale samples cannot produce a level right after rst.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_sh <= '0;
      end else if (w_tick) begin
        r_sh <= {r_s2[k], r_sh[DEPTH-1:1]};
      end
    end

    // Hysteresis: the level only moves once every sample in the window agrees.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_level <= 1'b0;
        r_prev  <= 1'b0;
      end else begin
        r_prev <= r_level;
        if (&r_sh) begin
          r_level <= 1'b1;
        end else if (~|r_sh) begin
          r_level <= 1'b0;
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_hold <= '0;
        r_long <= 1'b0;
      end else begin
        r_long <= r_level && w_tick && (r_hold == HOLD_PRE);
        if (!r_level) begin
          r_hold <= '0;
        end else if (w_tick && !w_hold_full) begin
          r_hold <= r_hold + HW'(1);
        end
      end
    end

    // Repeat phase only advances once the hold counter has saturated.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_rep       <= '0;
        r_rep_pulse <= 1'b0;
      end else begin
        r_rep_pulse <= REP_ON && r_level && w_hold_full && w_tick && (r_rep == REP_LAST);
        if (!r_level || !w_hold_full) begin
          r_rep <= '0;
        end else if (w_tick) begin
          if (r_rep == REP_LAST) begin
            r_rep <= '0;
          end else begin
            r_rep <= r_rep + RW'(1);
          end
        end
      end
    end

    assign o_level[k]   = r_level;
    assign o_press[k]   = r_level & ~r_prev;
    assign o_release[k] = ~r_level & r_prev;
    assign o_long[k]    = r_long;
    assign o_repeat[k]  = r_rep_pulse;
  end

endmodule

// File: tb/tb_button_debounce_multi.sv
// Self-checking bench for button_debounce_multi: directed scenarios plus random
// stimulus, compared every cycle against a tick/sample-history reference model.
module tb_button_debounce_multi;

  localparam int N  = 2;
  localparam int CD = 4;
  localparam int DP = 4;
  localparam int LT = 8;
  localparam int RE = 1;
  localparam int RT = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] i_btn = '0;
  logic [N-1:0] o_level, o_press, o_release, o_long, o_repeat;

  always #5 clk = ~clk;

  button_debounce_multi #(
    .N_BTN(N), .CLK_DIV(CD), .DEPTH(DP), .LONG_TICKS(LT),
    .REPEAT_EN(RE), .REPEAT_TICKS(RT)
  ) dut (
    .clk(clk), .rst(rst), .i_btn(i_btn),
    .o_level(o_level), .o_press(o_press), .o_release(o_release),
    .o_long(o_long), .o_repeat(o_repeat)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d (t=%0t)", name, act, lo, hi, $time);
    end
  endtask

  // Reference model: raw-sample delay line, list of tick samples, ticks-held count.
  logic [N-1:0] e_level   = '0;
  logic [N-1:0] e_press   = '0;
  logic [N-1:0] e_release = '0;
  logic [N-1:0] e_long    = '0;
  logic [N-1:0] e_repeat  = '0;
  logic [N-1:0] raw_q[$];
  logic [N-1:0] tsamp[$];
  int           m_n;
  int           m_ht[N];
  logic         m_tick;
  logic [N-1:0] m_s2, m_old, m_new;
  logic         m_ones, m_zeros;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_n = 0;
      raw_q = {};
      tsamp = {};
      for (int j = 0; j < DP; j++) tsamp.push_back('0);
      for (int k = 0; k < N; k++) m_ht[k] = 0;
      e_level = '0; e_press = '0; e_release = '0; e_long = '0; e_repeat = '0;
    end else begin
      m_tick = ((m_n % CD) == CD - 1);
      m_n++;
      m_s2 = (raw_q.size() >= 2) ? raw_q[1] : '0;
      raw_q.push_front(i_btn);
      while (raw_q.size() > 2) void'(raw_q.pop_back());
      m_old = e_level;
      for (int k = 0; k < N; k++) begin
        m_ones = 1'b1;
        m_zeros = 1'b1;
        for (int j = 0; j < DP; j++) begin
          if (tsamp[j][k]) m_zeros = 1'b0;
          else             m_ones  = 1'b0;
        end
        m_new[k] = m_ones ? 1'b1 : (m_zeros ? 1'b0 : m_old[k]);
      end
      if (m_tick) begin
        tsamp.push_back(m_s2);
        void'(tsamp.pop_front());
      end
      e_long = '0;
      e_repeat = '0;
      for (int k = 0; k < N; k++) begin
        if (!m_old[k]) begin
          m_ht[k] = 0;
        end else if (m_tick) begin
          m_ht[k]++;
          if (m_ht[k] == LT) e_long[k] = 1'b1;
          if (RE != 0 && m_ht[k] > LT && ((m_ht[k] - LT) % RT) == 0) e_repeat[k] = 1'b1;
        end
      end
      e_press   = m_new & ~m_old;
      e_release = ~m_new & m_old;
      e_level   = m_new;
    end
  end

  // Compare process and pulse bookkeeping
  int cyc = 0;
  int cnt_press[N] = '{default: 0};
  int cnt_rel[N]   = '{default: 0};
  int cnt_long[N]  = '{default: 0};
  int cnt_rep[N]   = '{default: 0};
  int last_press[N] = '{default: 0};
  int last_long[N]  = '{default: 0};
  int last_rep[N]   = '{default: 0};

  always @(posedge clk) begin
    cyc++;
    #1;
    check("level",   o_level,   e_level);
    check("press",   o_press,   e_press);
    check("release", o_release, e_release);
    check("long",    o_long,    e_long);
    check("repeat",  o_repeat,  e_repeat);
    for (int k = 0; k < N; k++) begin
      if (o_press[k] === 1'b1)   begin cnt_press[k]++; last_press[k] = cyc; end
      if (o_release[k] === 1'b1) cnt_rel[k]++;
      if (o_long[k] === 1'b1)    begin cnt_long[k]++; last_long[k] = cyc; end
      if (o_repeat[k] === 1'b1)  begin cnt_rep[k]++; last_rep[k] = cyc; end
    end
  end

  function automatic int cnt_of(input int which, input int ch);
    case (which)
      0:       return cnt_press[ch];
      1:       return cnt_rel[ch];
      2:       return cnt_long[ch];
      default: return cnt_rep[ch];
    endcase
  endfunction

  // which: 0 press, 1 release, 2 long, 3 repeat
  task automatic wait_pulse(input int which, input int ch, input int budget, input string name, output bit ok);
    int start;
    start = cnt_of(which, ch);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (cnt_of(which, ch) != start) ok = 1'b1;
    end
    if (!ok) check({name, "_timeout"}, {63'd0, ok}, 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int t0, p, l, r1, pr, rl, rat;
  bit ok;
  int dur[N];

  initial begin
    rst = 1'b1;
    i_btn = '0;
    repeat (3) @(negedge clk);
    check("rst_outputs", {o_level, o_press, o_release, o_long, o_repeat}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_outputs", {o_level, o_press, o_release, o_long, o_repeat}, 0);

    // Clean press on channel 0
    i_btn[0] = 1'b1;
    t0 = cyc;
    wait_pulse(0, 0, 40, "clean_press", ok);
    if (ok) check_range("clean_press_latency", last_press[0] - t0, 16, 19);
    check("clean_level", o_level[0], 1);
    @(negedge clk);
    check("press_width", o_press[0], 0);
    check("ch1_idle", cnt_press[1] + cnt_rel[1] + cnt_long[1] + cnt_rep[1], 0);

    // Glitch immunity while held
    pr = cnt_press[0]; rl = cnt_rel[0];
    i_btn[0] = 1'b0;
    repeat (4) @(negedge clk);
    i_btn[0] = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch_level", o_level[0], 1);
    check("glitch_edges", (cnt_press[0] - pr) + (cnt_rel[0] - rl), 0);

    i_btn[0] = 1'b0;
    wait_pulse(1, 0, 40, "release0", ok);
    repeat (5) @(negedge clk);

    // Bounce then settle high
    pr = cnt_press[0]; rl = cnt_rel[0];
    for (int i = 0; i < 40; i++) begin
      i_btn[0] = ((i / 3) % 2) == 0;
      @(negedge clk);
    end
    i_btn[0] = 1'b1;
    repeat (40) @(negedge clk);
    check("bounce_press", cnt_press[0] - pr, 1);
    check("bounce_release", cnt_rel[0] - rl, 0);
    i_btn[0] = 1'b0;
    wait_pulse(1, 0, 40, "bounce_rel", ok);
    repeat (5) @(negedge clk);

    // Long press and repeat on channel 1
    rl = cnt_rel[1];
    i_btn[1] = 1'b1;
    t0 = cyc;
    wait_pulse(0, 1, 40, "press1", ok);
    p = last_press[1];
    wait_pulse(2, 1, 60, "long1", ok);
    if (ok) check_range("long_after_press", last_long[1] - p, 29, 32);
    l = last_long[1];
    wait_pulse(3, 1, 30, "rep1", ok);
    if (ok) check("rep_first_gap", last_rep[1] - l, 12);
    r1 = last_rep[1];
    wait_pulse(3, 1, 30, "rep2", ok);
    if (ok) check("rep_second_gap", last_rep[1] - r1, 12);
    while (cyc - t0 < 120) @(negedge clk);
    i_btn[1] = 1'b0;
    wait_pulse(1, 1, 40, "release1", ok);
    rat = cnt_rep[1];
    repeat (40) @(negedge clk);
    check("rep_after_release", cnt_rep[1] - rat, 0);
    check("release_once", cnt_rel[1] - rl, 1);

    // Simultaneous press on both channels
    i_btn = 2'b11;
    for (int i = 0; i < 40 && o_press == '0; i++) @(negedge clk);
    check("simul_press", o_press, 2'b11);
    for (int i = 0; i < 60 && o_long == '0; i++) @(negedge clk);
    check("simul_long", o_long, 2'b11);
    i_btn = 2'b00;
    repeat (30) @(negedge clk);

    // Reset in the middle of a hold
    i_btn[0] = 1'b1;
    wait_pulse(0, 0, 40, "press_pre_rst", ok);
    repeat (10) @(negedge clk);
    rl = cnt_rel[0];
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mid_rst_outputs", {o_level, o_press, o_release, o_long, o_repeat}, 0);
    end
    rst = 1'b0;
    t0 = cyc;
    wait_pulse(0, 0, 40, "repress", ok);
    if (ok) check_range("repress_latency", last_press[0] - t0, 16, 19);
    check("rst_no_release", cnt_rel[0] - rl, 0);
    i_btn[0] = 1'b0;
    repeat (30) @(negedge clk);

    // Random held levels with random durations, checked by the model every cycle
    for (int k = 0; k < N; k++) dur[k] = 0;
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < N; k++) begin
        if (dur[k] == 0) begin
          i_btn[k] = $urandom_range(0, 1) == 1;
          dur[k] = $urandom_range(1, 60);
        end
        dur[k]--;
      end
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
